// File: rtl/sfifo.sv
// Synchronous single-clock FIFO. It has a registered read port and one-cycle
// overflow/underflow pulses. The pointers carry one extra wrap bit, which tells full from empty.
module sfifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status comes only from the registered pointers, so it never follows the request inputs combinationally.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]});
    end

    // When the FIFO is full, a write is still accepted if a read in the same cycle frees a slot.
    always_comb begin
        rd_acc = r_en && !empty;
        wr_acc = w_en && (!full || r_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= w_en && !wr_acc;
            underflow <= r_en && !rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (rd_acc) begin
                dout   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
        end
    end

    // Storage is not reset. Clearing the pointers makes any old contents unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

endmodule

// File: tb/tb_sfifo.sv
// Testbench for sfifo. A queue-based reference model is checked against the DUT
// every cycle. The run covers directed scenarios and randomized traffic with occasional resets.
module tb_sfifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, overflow, underflow;

    int n_vec  = 0;
    int n_miss = 0;
    bit check_en = 1'b0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_ov = 1'b0;
    bit            m_un = 1'b0;

    sfifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en),
        .dout(dout), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: occupancy is the queue length, and order is push_back/pop_front.
    always @(posedge clk) begin
        bit rd_ok, wr_ok;
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_ov   = 1'b0;
            m_un   = 1'b0;
        end else begin
            rd_ok = r_en && (q.size() > 0);
            wr_ok = w_en && ((q.size() < DEPTH) || r_en);
            m_ov  = w_en && !wr_ok;
            m_un  = r_en && !rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("dout",      32'(dout),      32'(m_dout));
            chk("full",      32'(full),      32'(q.size() == DEPTH));
            chk("empty",     32'(empty),     32'(q.size() == 0));
            chk("overflow",  32'(overflow),  32'(m_ov));
            chk("underflow", 32'(underflow), 32'(m_un));
        end
    end

    task automatic tick(input bit w, input logic [DW-1:0] d, input bit r);
        @(negedge clk);
        w_en = w;
        din  = d;
        r_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, '0, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for four cycles, then one idle cycle.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) idle();
        check_en = 1'b1;
        rst = 1'b0;
        idle();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_unf",   32'(underflow), 32'd0);
        chk("rst_dout",  32'(dout),  32'h00);

        // Writes separated by idle cycles, then four reads in a row.
        tick(1'b1, 8'h75, 1'b0);
        tick(1'b1, 8'h76, 1'b0);
        tick(1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        tick(1'b1, 8'h78, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1);
            chk("seq_dout", 32'(dout), 32'(8'h75 + i));
        end
        chk("seq_empty", 32'(empty), 32'd1);

        // Underflow while empty.
        tick(1'b0, '0, 1'b1);
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_dout",  32'(dout), 32'h78);
        chk("unf_empty", 32'(empty), 32'd1);
        idle();
        chk("unf_clear", 32'(underflow), 32'd0);

        // Fill to full, then a rejected 17th write.
        for (int i = 0; i < 16; i++) tick(1'b1, DW'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        tick(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_full",  32'(full), 32'd1);
        idle();
        chk("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, '0, 1'b1);
            chk("drain_dout", 32'(dout), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Simultaneous read and write while full.
        for (int i = 0; i < 16; i++) tick(1'b1, DW'(8'h10 + i), 1'b0);
        tick(1'b1, 8'h55, 1'b1);
        chk("rw_full_dout", 32'(dout), 32'h10);
        chk("rw_full_full", 32'(full), 32'd1);
        chk("rw_full_ovf",  32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) tick(1'b0, '0, 1'b1);
        chk("rw_full_last", 32'(dout), 32'h55);

        // Pointer wrap-around.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) tick(1'b1, DW'(8'h20 + 16 * pass + i), 1'b0);
            for (int i = 0; i < 10; i++) begin
                tick(1'b0, '0, 1'b1);
                chk("wrap_dout", 32'(dout), 32'(8'h20 + 16 * pass + i));
            end
            chk("wrap_empty", 32'(empty), 32'd1);
        end

        // Reset with words still stored.
        for (int i = 0; i < 5; i++) tick(1'b1, DW'(8'hC0 + i), 1'b0);
        rst = 1'b1;
        tick(1'b1, 8'hEE, 1'b1);
        rst = 1'b0;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_dout",  32'(dout), 32'h00);
        tick(1'b1, 8'h99, 1'b0);
        tick(1'b0, '0, 1'b1);
        chk("midrst_after", 32'(dout), 32'h99);

        // Randomized traffic with phases of different fill pressure.
        for (int i = 0; i < 3000; i++) begin
            int unsigned wp, rp;
            wp = ((i / 200) % 3 == 0) ? 80 : (((i / 200) % 3 == 1) ? 25 : 55);
            rp = 100 - wp;
            rst = ($urandom_range(0, 199) == 0);
            tick($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp);
        end
        rst = 1'b0;
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sfifo.md
SFIFO -- requirements
Module: sfifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 4, log2(DEPTH).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 w_en  input  1  write request, sampled at the rising clk edge.
REQ-007 din  input  DATA_WIDTH  write data, sampled with w_en.
REQ-008 r_en  input  1  read request, sampled at the rising clk edge.
REQ-009 dout  output  DATA_WIDTH  registered read data.
REQ-010 full  output  1  high when the FIFO holds DEPTH words.
REQ-011 empty  output  1  high when the FIFO holds 0 words.
REQ-012 overflow  output  1  registered one-cycle pulse: the previous edge saw a rejected write.
REQ-013 underflow  output  1  registered one-cycle pulse: the previous edge saw a rejected read.

Function
REQ-014 Storage SHALL be a DEPTH x DATA_WIDTH array with write and read pointers of ADDR_WIDTH+1 bits; the extra MSB distinguishes full from empty.
REQ-015 empty SHALL be 1 when the pointers are equal; full SHALL be 1 when the pointers differ only in the MSB.
REQ-016 full and empty SHALL derive combinationally from the registered pointers, so each reflects the state after the most recent edge.
REQ-017 Write accepted = w_en && (!full || r_en); on acceptance, din is stored at wr_ptr[ADDR_WIDTH-1:0] and wr_ptr increments by 1, modulo 2^(ADDR_WIDTH+1).
REQ-018 Read accepted = r_en && !empty; on acceptance, mem[rd_ptr] is loaded into dout at that edge (one-cycle latency) and rd_ptr increments by 1, modulo 2^(ADDR_WIDTH+1).
REQ-019 dout SHALL hold its last value on any cycle without an accepted read.
REQ-020 Simultaneous accepted read and write SHALL leave occupancy unchanged; when full, the read frees the slot and the write is accepted in the same cycle.
REQ-021 When empty, a simultaneous read SHALL be rejected (no write-through to dout); the write is accepted.
REQ-022 A rejected write (w_en && full && !r_en) SHALL leave the memory and wr_ptr unchanged and set overflow for exactly one cycle.
REQ-023 A rejected read (r_en && empty) SHALL leave rd_ptr and dout unchanged and set underflow for exactly one cycle.
REQ-024 overflow and underflow SHALL deassert on the next edge unless the error repeats; repeated errors keep the flag high.
REQ-025 Pointer wrap-around SHALL be seamless; data order SHALL be strictly first-in first-out.
REQ-026 Words stored and read back SHALL be bit-exact; no flag or data output may depend combinationally on w_en, r_en or din.

Reset
REQ-027 While rst=1 at a rising edge: wr_ptr=0, rd_ptr=0, dout=0, overflow=0, underflow=0; therefore empty=1 and full=0 after that edge.
REQ-028 Reset SHALL take priority over simultaneous w_en and r_en; memory contents need not be cleared.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; the next write after deassertion lands at address 0.

Verification
REQ-030 Reset for 4 cycles, then idle -> empty=1, full=0, overflow=0, underflow=0, dout=0x00.
REQ-031 Write 0x75, 0x76, 0x77, idle 3 cycles, write 0x78, then read 4 times -> dout 0x75, 0x76, 0x77, 0x78 on successive edges; empty=1 after the 4th read.
REQ-032 Write 16 words 0x00..0x0F -> full=1 after the 16th write; a 17th write of 0xAA -> overflow high for one cycle, then 16 reads return 0x00..0x0F with no 0xAA.
REQ-033 Read while empty -> underflow high for one cycle, dout unchanged, empty stays 1.
REQ-034 With full=1, assert w_en=1 (din=0x55) and r_en=1 together -> dout=oldest word, full stays 1, no overflow; 0x55 is read last.
REQ-035 Write 10, read 10, write 10, read 10 (pointer wrap) -> data in order, flags correct; a reset with 5 words stored -> empty=1 on the next edge.
